// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// Holds the FSM state enum and the drain timeout helper.
package spi_seq_pkg;

   typedef enum logic [3:0] {
      S_DRAIN,
      S_IDLE,
      S_SETUP,
      S_LOAD,
      S_KICK,
      S_WAIT_LO,
      S_WAIT_HI,
      S_HOLD,
      S_GAP
   } state_e;

   localparam int CNT_W = 16;

   // Worst-case length of a core transfer left running across reset.
   function automatic int drain_max(input int dw);
      return 10 * dw + 8;
   endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter with a zero flag.
// Shared by the setup, hold, gap and drain timers.
module spi_delay_cnt #(
   parameter int           W       = 16,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load has priority; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= RST_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// Frames multi-word SPI transactions around the byte-wide master core.
// Owns slave select timing and the core's cs/wr/din strobes.
module spi_xfer_seq
   import spi_seq_pkg::*;
#(
   parameter int DWIDTH   = 8,
   parameter int NUM_SS   = 2,
   parameter int LEN_W    = 8,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2,
   localparam int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [SEL_W-1:0]  ss_sel_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [DWIDTH-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DWIDTH-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [NUM_SS-1:0] ss_n_o,
   output logic              core_cs_o,
   output logic              core_wr_o,
   output logic              core_rd_o,
   output logic [DWIDTH-1:0] core_din_o,
   input  logic [DWIDTH-1:0] core_dout_i,
   input  logic              core_done_i
);

   localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(drain_max(DWIDTH) - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;
   logic [DWIDTH-1:0] din_q, din_d;
   logic [DWIDTH-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              done_q, done_d;

   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_dec;
   logic              cnt_zero;
   logic              sel_ok;
   logic [NUM_SS-1:0] sel_mask;

   spi_delay_cnt #(
      .W       (CNT_W),
      .RST_VAL (DRAIN_LD)
   ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Next-state, timer control and datapath updates.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      ss_n_d     = ss_n_q;
      din_d      = din_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      cnt_dec    = 1'b0;
      sel_ok     = (32'(ss_sel_i) < NUM_SS);
      sel_mask   = ~(NUM_SS'(1) << ss_sel_i);
      unique case (state_q)
         S_DRAIN: begin
            if (core_done_i || cnt_zero)
               state_d = S_IDLE;
            else
               cnt_dec = 1'b1;
         end
         S_IDLE: begin
            if (start_i) begin
               if (len_i == '0 || !sel_ok) begin
                  done_d   = 1'b1;
                  state_d  = S_GAP;
                  cnt_load = 1'b1;
                  cnt_val  = IDLE_LD;
               end else begin
                  rem_d    = len_i;
                  ss_n_d   = sel_mask;
                  state_d  = S_SETUP;
                  cnt_load = 1'b1;
                  cnt_val  = SETUP_LD;
               end
            end
         end
         S_SETUP: begin
            if (cnt_zero)
               state_d = S_LOAD;
            else
               cnt_dec = 1'b1;
         end
         S_LOAD: begin
            if (tx_valid_i) begin
               din_d   = tx_data_i;
               state_d = S_KICK;
            end
         end
         S_KICK: begin
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!core_done_i)
               state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (core_done_i) begin
               rx_data_d  = core_dout_i;
               rx_valid_d = 1'b1;
               rem_d      = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d  = S_HOLD;
                  cnt_load = 1'b1;
                  cnt_val  = HOLD_LD;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_HOLD: begin
            if (cnt_zero) begin
               ss_n_d   = '1;
               done_d   = 1'b1;
               state_d  = S_GAP;
               cnt_load = 1'b1;
               cnt_val  = IDLE_LD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_zero)
               state_d = S_IDLE;
            else
               cnt_dec = 1'b1;
         end
         default: state_d = S_DRAIN;
      endcase
   end

   // State and registered outputs; reset restarts in drain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_DRAIN;
         rem_q      <= '0;
         ss_n_q     <= '1;
         din_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         ss_n_q     <= ss_n_d;
         din_q      <= din_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
      end
   end

   assign tx_ready_o = (state_q == S_LOAD);
   assign core_cs_o  = (state_q == S_KICK);
   assign core_wr_o  = (state_q == S_KICK);
   assign core_rd_o  = 1'b0;
   assign core_din_o = din_q;
   assign busy_o     = (state_q != S_IDLE);
   assign ss_n_o     = ss_n_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq with a behavioural echo core.
// Table of transactions plus hand-written reset sequences.
module tb_spi_xfer_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [0:0] sel;
   logic [7:0] len;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic [1:0] ss_n;
   logic       core_cs;
   logic       core_wr;
   logic       core_rd;
   logic [7:0] core_din;
   logic [7:0] core_dout = 8'h00;
   logic       core_done = 1'b1;

   logic [7:0] prev_byte = 8'h5A;
   logic [7:0] lat_byte  = 8'h00;
   int         ccnt      = 0;

   int n_checks = 0;
   int n_errors = 0;

   int         cyc = 0;
   int         wr_n, done_n, rx_n;
   logic [7:0] rx_buf [16];
   logic [1:0] ss_mask;
   logic [1:0] ss_at_done;
   int         ready_cyc, done_cyc, last_rxv, idle_cyc, cdone_rise;
   logic       prev_busy  = 1'b1;
   logic       prev_cdone = 1'b1;

   spi_xfer_seq dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .ss_sel_i    (sel),
      .len_i       (len),
      .tx_data_i   (tx_data),
      .tx_valid_i  (tx_valid),
      .tx_ready_o  (tx_ready),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .busy_o      (busy),
      .done_o      (done),
      .ss_n_o      (ss_n),
      .core_cs_o   (core_cs),
      .core_wr_o   (core_wr),
      .core_rd_o   (core_rd),
      .core_din_o  (core_din),
      .core_dout_i (core_dout),
      .core_done_i (core_done)
   );

   always #5 clk = ~clk;

   // Echo core: 8-cycle transfer, returns the byte sent last time.
   always @(posedge clk) begin
      if (core_wr) begin
         core_done <= 1'b0;
         ccnt      <= 8;
         lat_byte  <= core_din;
      end else if (ccnt != 0) begin
         ccnt <= ccnt - 1;
         if (ccnt == 1) begin
            core_done <= 1'b1;
            core_dout <= prev_byte;
            prev_byte <= lat_byte;
         end
      end
   end

   typedef struct {
      logic            sel;
      logic [7:0]      len;
      logic [2:0][7:0] tx;
      logic [2:0][7:0] rx;
      logic [1:0]      mask;
      int              stall;
      bit              stray;
   } vec_t;

   vec_t tv [5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Advance to the next falling edge and record observations.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (core_wr) wr_n++;
      if (done) begin
         done_n++;
         done_cyc   = cyc;
         ss_at_done = ss_n;
      end
      if (rx_valid) begin
         if (rx_n < 16) rx_buf[rx_n] = rx_data;
         rx_n++;
         last_rxv = cyc;
      end
      ss_mask = ss_mask | ~ss_n;
      if (tx_ready && ready_cyc < 0) ready_cyc = cyc;
      if (!busy && prev_busy) idle_cyc = cyc;
      if (core_done && !prev_cdone) cdone_rise = cyc;
      prev_busy  = busy;
      prev_cdone = core_done;
   endtask

   task automatic clear_track();
      wr_n = 0; done_n = 0; rx_n = 0; ss_mask = 2'b00;
      ss_at_done = 2'b00;
      ready_cyc = -1; done_cyc = -1; last_rxv = -1;
      idle_cyc = -1; cdone_rise = -1;
   endtask

   task automatic run_row(input int r, input vec_t v);
      int sc;
      int to;
      int wb;
      clear_track();
      sel   = v.sel;
      len   = v.len;
      start = 1'b1;
      sc    = cyc;
      tick();
      start = 1'b0;
      for (int w = 0; w < int'(v.len); w++) begin
         if (w == 1 && v.stall > 0) begin
            wb = wr_n;
            repeat (v.stall) tick();
            chk($sformatf("row%0d_stall_wr", r), wr_n - wb, 0);
            chk($sformatf("row%0d_stall_ss", r), {30'd0, ss_n},
                {30'd0, ~v.mask});
            chk($sformatf("row%0d_stall_rdy", r), {31'd0, tx_ready}, 1);
         end
         tx_data  = v.tx[w];
         tx_valid = 1'b1;
         to = 0;
         while (!tx_ready && to < 200) begin
            tick();
            to++;
         end
         if (to >= 200)
            chk($sformatf("row%0d_rdy_timeout", r), 0, 1);
         tick();
         tx_valid = 1'b0;
         if (v.stray && w == 0) begin
            repeat (3) tick();
            start = 1'b1;
            sel   = ~v.sel;
            len   = 8'd1;
            tick();
            start = 1'b0;
         end
      end
      to = 0;
      while (done_n == 0 && to < 500) begin
         tick();
         to++;
      end
      if (v.stray) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      to = 0;
      while (busy && to < 500) begin
         tick();
         to++;
      end
      chk($sformatf("row%0d_idle", r), {31'd0, busy}, 0);
      if (v.len != 0) begin
         chk($sformatf("row%0d_setup_lat", r), ready_cyc - sc, 3);
         chk($sformatf("row%0d_hold_lat", r), done_cyc - last_rxv, 2);
      end else begin
         chk($sformatf("row%0d_done_lat", r), done_cyc - sc, 1);
      end
      chk($sformatf("row%0d_gap_lat", r), idle_cyc - done_cyc, 2);
      chk($sformatf("row%0d_wr_n", r), wr_n, {24'd0, v.len});
      chk($sformatf("row%0d_done_n", r), done_n, 1);
      chk($sformatf("row%0d_rx_n", r), rx_n, {24'd0, v.len});
      chk($sformatf("row%0d_ss_mask", r), {30'd0, ss_mask},
          {30'd0, v.mask});
      chk($sformatf("row%0d_ss_done", r), {30'd0, ss_at_done}, 3);
      for (int w = 0; w < int'(v.len) && w < rx_n; w++)
         chk($sformatf("row%0d_rx%0d", r, w), {24'd0, rx_buf[w]},
             {24'd0, v.rx[w]});
   endtask

   initial begin
      int to;
      int dn;
      int rv;
      tv[0] = '{1'b1, 8'd3, {8'hFF, 8'h3C, 8'hA5},
                {8'h3C, 8'hA5, 8'h5A}, 2'b10, 0, 1'b0};
      tv[1] = '{1'b0, 8'd2, {8'h00, 8'h22, 8'h11},
                {8'h00, 8'h11, 8'hFF}, 2'b01, 40, 1'b0};
      tv[2] = '{1'b0, 8'd0, {8'h00, 8'h00, 8'h00},
                {8'h00, 8'h00, 8'h00}, 2'b00, 0, 1'b0};
      tv[3] = '{1'b1, 8'd2, {8'h00, 8'h0F, 8'hC3},
                {8'h00, 8'hC3, 8'h22}, 2'b10, 0, 1'b1};
      tv[4] = '{1'b0, 8'd1, {8'h00, 8'h00, 8'h77},
                {8'h00, 8'h00, 8'h0F}, 2'b01, 0, 1'b0};

      rst = 1'b1; start = 1'b0; sel = 1'b0; len = 8'd0;
      tx_data = 8'h00; tx_valid = 1'b0;
      clear_track();
      repeat (2) tick();
      chk("rst_ctl", {24'd0, busy, ss_n, tx_ready, rx_valid, done,
                      core_cs, core_wr}, 32'h0000_00E0);
      chk("rst_data", {16'd0, rx_data, core_din}, 0);
      chk("rst_rd", {31'd0, core_rd}, 0);
      rst = 1'b0;
      tick();
      chk("drain_exit", {31'd0, busy}, 0);
      chk("drain_ss", {30'd0, ss_n}, 3);

      for (int r = 0; r < 5; r++)
         run_row(r, tv[r]);

      clear_track();
      sel = 1'b0; len = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      tx_data = 8'h88; tx_valid = 1'b1;
      to = 0;
      while (!tx_ready && to < 200) begin
         tick();
         to++;
      end
      if (to >= 200) chk("rst_rdy_timeout", 0, 1);
      tick();
      tx_valid = 1'b0;
      repeat (3) tick();
      chk("pre_rst_ss", {30'd0, ss_n}, 2);
      dn = done_n;
      rv = rx_n;
      rst = 1'b1;
      #1;
      chk("rst_async", {25'd0, busy, ss_n, tx_ready, rx_valid, done,
                        core_wr}, 32'h0000_0070);
      tick();
      rst = 1'b0;
      cdone_rise = -1;
      idle_cyc   = -1;
      tick();
      chk("drain_hold", {30'd0, busy, core_done}, 2);
      to = 0;
      while (busy && to < 200) begin
         tick();
         to++;
      end
      chk("drain_idle", {31'd0, busy}, 0);
      chk("drain_lat", idle_cyc - cdone_rise, 1);
      chk("rst_no_pulse", (done_n - dn) + (rx_n - rv), 0);
      chk("drain_ss_hi", {30'd0, ss_n}, 3);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Transaction sequencer for the byte-wide SPI master core. It turns one host command into a framed, multi-word SPI transaction: slave select is asserted with setup and hold margins, each word is fed to the core with a single-cycle write strobe, and the word shifted back is returned to the host. It sits between the host/bus logic and the SPI master core, and it is the only block that drives the core's `cs`/`wr`/`rd`/`din` inputs.

## Interface
- `DWIDTH`, 8, word width; must equal the core's `DWIDTH`.
- `NUM_SS`, 2, number of slave-select lines.
- `LEN_W`, 8, width of the word-count field.
- `CS_SETUP`, 2, clk cycles from `ss_n` assertion to the first core start (≥1).
- `CS_HOLD`, 2, clk cycles from the last core done to `ss_n` deassertion (≥1).
- `CS_IDLE`, 2, minimum clk cycles `ss_n` stays high between transactions (≥1).

Ports:
- `clk` in 1: single clock, shared with the SPI core.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: command strobe; accepted only while `busy`=0.
- `ss_sel` in max(1,$clog2(NUM_SS)): slave index, sampled with `start`.
- `len` in LEN_W: word count, sampled with `start`.
- `tx_data` in DWIDTH: next word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: word accepted when `tx_valid`&`tx_ready`.
- `rx_data` out DWIDTH: received word.
- `rx_valid` out 1: one-cycle pulse; no backpressure.
- `busy` out 1: a transaction, gap or drain is in progress.
- `done` out 1: one-cycle pulse at transaction end.
- `ss_n` out NUM_SS: active-low selects; at most one is low.
- `core_cs`, `core_wr`, `core_rd` out 1: core strobes; `core_rd` is tied to 0.
- `core_din` out DWIDTH: word presented to the core.
- `core_dout` in DWIDTH: core's received word.
- `core_done` in 1: core done level.

## Operation
- States: DRAIN, IDLE, SETUP, LOAD, KICK, WAIT_LO, WAIT_HI, HOLD, GAP.
- Reset values: state=DRAIN; `ss_n` all 1; `core_cs`=`core_wr`=0; `tx_ready`=`rx_valid`=`done`=0; `busy`=1; `rx_data`=`core_din`=0.
- DRAIN: the core has no reset, so a transfer may still be running. Stay in DRAIN until `core_done`=1 or until DRAIN_MAX = 10*DWIDTH+8 cycles have elapsed, then go to IDLE.
- IDLE: `busy`=0. On `start`:
  - if `len`=0: pulse `done` next cycle, never assert `ss_n`, go to GAP.
  - otherwise: latch `ss_sel` and `len` into the remaining-word count, drive `ss_n[ss_sel]` low, go to SETUP.
  - If `ss_sel`≥NUM_SS, the command is treated as `len`=0.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD: `tx_ready`=1. On handshake, register `tx_data` into `core_din` and go to KICK. If `tx_valid` is low, stall indefinitely with `ss_n` held low (sclk is idle).
- KICK: `core_cs`=`core_wr`=1 for exactly one cycle, then go to WAIT_LO.
- WAIT_LO: wait for `core_done`=0, then go to WAIT_HI. The core's done is a level that clears after a start.
- WAIT_HI: on `core_done`=1:
  - capture `core_dout` into `rx_data` and pulse `rx_valid` next cycle;
  - decrement the count;
  - if count>0, go to LOAD; otherwise go to HOLD.
- HOLD: count CS_HOLD cycles, drive `ss_n` all high, pulse `done`, go to GAP.
- GAP: count CS_IDLE cycles, then go to IDLE.
- `core_din` is stable from the LOAD handshake through WAIT_HI.
- `start` while `busy`=1 is ignored.

## Timing
- Sampled `start` (len≥1) at edge 0: `busy`=1 and `ss_n` low from edge 1; `tx_ready` first high at edge 1+CS_SETUP.
- Handshake at edge t: `core_wr` high during cycle t+1 only.
- WAIT_HI sees `core_done` at edge u: `rx_valid` is high for cycle u+1.
- Last done at edge u: `ss_n` rises and `done` pulses at edge u+CS_HOLD+1; `busy` falls CS_IDLE cycles later.
- Reset asserted mid-transaction: all outputs immediately take reset values (asynchronous); no `done` or `rx_valid` pulse is emitted.

## Structure
- Package `spi_seq_pkg`: state enum and the DRAIN_MAX constant function.
- One natural sub-module: `spi_delay_cnt`, a loadable down-counter with a zero flag, reused for SETUP, HOLD, GAP and DRAIN.
- The SPI core is not instantiated here; the top level wires the two blocks together.

## Test plan
- Reset, core idle (`core_done`=1): leave DRAIN in 1 cycle; `busy`=0 by cycle 3; `ss_n`=2'b11 throughout.
- `len`=3, `ss_sel`=1, tx 0xA5/0x3C/0xFF, slave echoes the previous byte: `ss_n`=2'b01; rx = prior/0xA5/0x3C; exactly 3 `core_wr` pulses; one `done`.
- `tx_valid` withheld 40 cycles before byte 2: `ss_n` stays low, no `core_wr`, transaction completes normally.
- `len`=0: `done` pulses 1 cycle after `start`; `ss_n` never falls; no `core_wr`.
- `start` asserted during WAIT_HI and during GAP: ignored; the next `start` after `busy`=0 is accepted.
- Reset asserted in WAIT_HI: `ss_n` goes high within the same cycle; DRAIN waits for `core_done`, then IDLE.
